// File: rtl/led_driver_pkg.sv
// led_driver_pkg: shared types and constants for the LED driver output stage.
//   ledout_mode_t : per-LED source select carried in the LEDOUT register
//   MODE_*        : bit positions inside the MODE register
package led_driver_pkg;

  typedef enum logic [1:0] {
    LED_OFF = 2'b00,
    LED_ON  = 2'b01,
    LED_PWM = 2'b10,
    LED_GRP = 2'b11
  } ledout_mode_t;

  localparam int unsigned MODE_INVRT  = 2;
  localparam int unsigned MODE_DMBLNK = 3;
  localparam int unsigned MODE_SLEEP  = 4;

  localparam int unsigned NUM_LEDS = 4;
  localparam int unsigned DUTY_W   = 8;

endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: divides clk into a one-cycle tick every DIV clocks.
//   clk     in  system clock
//   reset_n in  synchronous active-low reset
//   hold    in  forces the counter to 0 and suppresses the tick
//   tick    out high on the cycle the counter equals DIV-1 (combinational)
module led_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running 0..DIV-1 counter, parked at 0 while held.
  always_ff @(posedge clk) begin
    if (!reset_n || hold) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !hold && (cnt == LAST);

endmodule

// File: rtl/led_pwm_engine.sv
// led_pwm_engine: LED output stage. 8-bit individual PWM per LED, group
// dimmer or group blinker, invert and sleep, with double-buffered duties.
//   clk, reset_n             system clock, synchronous active-low reset
//   mode                     MODE register (INVRT, DMBLNK, SLEEP bits)
//   ledout                   LEDOUT register, 2 bits per LED
//   pwm0..pwm3               individual duty values
//   grppwm, grpfreq          group duty and group blink period
//   leds                     registered LED drive
module led_pwm_engine
  import led_driver_pkg::*;
#(
  parameter int unsigned PWM_DIV   = 4,
  parameter int unsigned BLINK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] mode,
  input  logic [7:0] ledout,
  input  logic [7:0] pwm0,
  input  logic [7:0] pwm1,
  input  logic [7:0] pwm2,
  input  logic [7:0] pwm3,
  input  logic [7:0] grppwm,
  input  logic [7:0] grpfreq,
  output logic [3:0] leds
);

  logic sleep;
  logic invrt;
  logic dmblnk;

  assign sleep  = mode[MODE_SLEEP];
  assign invrt  = mode[MODE_INVRT];
  assign dmblnk = mode[MODE_DMBLNK];

  logic pwm_tick;
  logic blink_tick;

  led_prescaler #(.DIV(PWM_DIV)) u_pwm_pre (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (sleep),
    .tick    (pwm_tick)
  );

  led_prescaler #(.DIV(BLINK_DIV)) u_blink_pre (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (sleep),
    .tick    (blink_tick)
  );

  logic [DUTY_W-1:0] ind_cnt;
  logic [DUTY_W-1:0] gdim_cnt;
  logic [DUTY_W-1:0] blink_unit;
  logic [DUTY_W-1:0] blink_sub;
  logic [DUTY_W-1:0] sh_pwm [NUM_LEDS];
  logic [DUTY_W-1:0] sh_grppwm;
  logic [DUTY_W-1:0] sh_grpfreq;
  logic [DUTY_W-1:0] pwm_in [NUM_LEDS];

  logic ind_wrap;
  logic sub_wrap;
  logic blink_wrap;

  always_comb begin
    pwm_in[0] = pwm0;
    pwm_in[1] = pwm1;
    pwm_in[2] = pwm2;
    pwm_in[3] = pwm3;
  end

  assign ind_wrap   = pwm_tick && (ind_cnt == 8'hFF);
  assign sub_wrap   = blink_tick && (blink_sub == 8'hFF);
  assign blink_wrap = sub_wrap && (blink_unit == sh_grpfreq);

  // Period counters and duty shadows. Sleep parks every counter at 0 and keeps
  // the shadows transparent so waking starts a clean period with fresh duties.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ind_cnt    <= '0;
      gdim_cnt   <= '0;
      blink_unit <= '0;
      blink_sub  <= '0;
      sh_grppwm  <= '0;
      sh_grpfreq <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        sh_pwm[i] <= '0;
      end
    end else if (sleep) begin
      ind_cnt    <= '0;
      gdim_cnt   <= '0;
      blink_unit <= '0;
      blink_sub  <= '0;
      sh_grppwm  <= grppwm;
      sh_grpfreq <= grpfreq;
      for (int i = 0; i < NUM_LEDS; i++) begin
        sh_pwm[i] <= pwm_in[i];
      end
    end else begin
      if (pwm_tick) begin
        ind_cnt <= ind_cnt + 8'd1;
      end
      if (ind_wrap) begin
        gdim_cnt  <= gdim_cnt + 8'd1;
        sh_grppwm <= grppwm;
        for (int i = 0; i < NUM_LEDS; i++) begin
          sh_pwm[i] <= pwm_in[i];
        end
      end
      if (blink_tick) begin
        blink_sub <= blink_sub + 8'd1;
      end
      if (sub_wrap) begin
        blink_unit <= blink_wrap ? 8'd0 : blink_unit + 8'd1;
      end
      if (blink_wrap) begin
        sh_grpfreq <= grpfreq;
      end
    end
  end

  logic [15:0] blink_pos;
  logic [15:0] blink_lim;
  logic        grp_gate;
  logic [3:0]  ind_gate;
  logic [3:0]  raw;

  assign blink_pos = {blink_unit, blink_sub};
  // Max 255 * 256 = 65280, so the 16-bit product never overflows.
  assign blink_lim = 16'(sh_grppwm) * (16'(sh_grpfreq) + 16'd1);

  // Per-LED source select and gating.
  always_comb begin
    grp_gate = dmblnk ? (blink_pos < blink_lim) : (gdim_cnt < sh_grppwm);
    ind_gate = '0;
    raw      = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      ind_gate[i] = (ind_cnt < sh_pwm[i]);
      case (ledout_mode_t'(ledout[2*i +: 2]))
        LED_OFF: raw[i] = 1'b0;
        LED_ON:  raw[i] = 1'b1;
        LED_PWM: raw[i] = ind_gate[i];
        LED_GRP: raw[i] = ind_gate[i] && grp_gate;
        default: raw[i] = 1'b0;
      endcase
    end
  end

  // Output register; sleep wins over invert.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      leds <= 4'b0000;
    end else if (sleep) begin
      leds <= 4'b0000;
    end else begin
      leds <= invrt ? ~raw : raw;
    end
  end

endmodule

// File: tb/tb_led_pwm_engine.sv
// tb_led_pwm_engine: scoreboard bench for led_pwm_engine with both dividers = 1.
// A behavioural model predicts leds each cycle; predictions are queued when the
// stimulus is applied and compared after the clock edge. Duty windows are also
// counted and checked against fixed values.
module tb_led_pwm_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] mode;
  logic [7:0] ledout;
  logic [7:0] pwm0, pwm1, pwm2, pwm3;
  logic [7:0] grppwm;
  logic [7:0] grpfreq;
  logic [3:0] leds;

  always #5 clk = ~clk;

  led_pwm_engine #(.PWM_DIV(1), .BLINK_DIV(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (mode),
    .ledout  (ledout),
    .pwm0    (pwm0),
    .pwm1    (pwm1),
    .pwm2    (pwm2),
    .pwm3    (pwm3),
    .grppwm  (grppwm),
    .grpfreq (grpfreq),
    .leds    (leds)
  );

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q [$];

  int m_ind, m_gdim, m_sub, m_unit;
  int m_sh_pwm [4];
  int m_sh_grp, m_sh_freq;
  int cnt0, cnt3;
  int c0, c3;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected leds after the next edge, from the model's pre-edge state.
  function automatic logic [3:0] model_leds();
    logic [3:0] r;
    logic       grp;
    logic       ind;
    int         f;
    if (!reset_n || mode[4]) return 4'b0000;
    if (mode[3]) grp = ((m_unit * 256 + m_sub) < (m_sh_grp * (m_sh_freq + 1)));
    else         grp = (m_gdim < m_sh_grp);
    for (int i = 0; i < 4; i++) begin
      f   = (int'(ledout) >> (2 * i)) & 3;
      ind = (m_ind < m_sh_pwm[i]);
      case (f)
        0:       r[i] = 1'b0;
        1:       r[i] = 1'b1;
        2:       r[i] = ind;
        default: r[i] = ind && grp;
      endcase
    end
    return mode[2] ? ~r : r;
  endfunction

  task automatic load_ind_shadows();
    m_sh_pwm[0] = int'(pwm0);
    m_sh_pwm[1] = int'(pwm1);
    m_sh_pwm[2] = int'(pwm2);
    m_sh_pwm[3] = int'(pwm3);
    m_sh_grp    = int'(grppwm);
  endtask

  task automatic model_update();
    if (!reset_n) begin
      m_ind = 0; m_gdim = 0; m_sub = 0; m_unit = 0;
      m_sh_grp = 0; m_sh_freq = 0;
      for (int i = 0; i < 4; i++) m_sh_pwm[i] = 0;
    end else if (mode[4]) begin
      m_ind = 0; m_gdim = 0; m_sub = 0; m_unit = 0;
      load_ind_shadows();
      m_sh_freq = int'(grpfreq);
    end else begin
      if (m_ind == 255) begin
        m_ind  = 0;
        m_gdim = (m_gdim + 1) % 256;
        load_ind_shadows();
      end else begin
        m_ind++;
      end
      if (m_sub == 255) begin
        m_sub = 0;
        if (m_unit == m_sh_freq) begin
          m_unit    = 0;
          m_sh_freq = int'(grpfreq);
        end else begin
          m_unit++;
        end
      end else begin
        m_sub++;
      end
    end
  endtask

  // One clock: queue prediction, advance model, sample #1 after the edge.
  task automatic step();
    logic [3:0] e;
    exp_q.push_back(model_leds());
    model_update();
    @(posedge clk);
    #1;
    check_eq("sb_depth", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("leds", int'(leds), int'(e));
    end
    cnt0 += int'(leds[0]);
    cnt3 += int'(leds[3]);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic win(input int n, output int o0, output int o3);
    cnt0 = 0;
    cnt3 = 0;
    run(n);
    o0 = cnt0;
    o3 = cnt3;
  endtask

  initial begin
    reset_n = 1'b0;
    mode    = 8'h00;
    ledout  = 8'h55;
    pwm0 = 8'h00; pwm1 = 8'h00; pwm2 = 8'h00; pwm3 = 8'h00;
    grppwm  = 8'h00;
    grpfreq = 8'h00;
    cnt0 = 0; cnt3 = 0;

    // Reset with all LEDs forced on
    step();
    check_eq("rst_cycle0", int'(leds), 0);
    step();
    check_eq("rst_cycle1", int'(leds), 0);
    reset_n = 1'b1;
    step();
    check_eq("rst_release", int'(leds), 15);

    // Individual PWM and double-buffered duty change
    reset_n = 1'b0;
    ledout = 8'hAA; pwm0 = 8'h40; pwm1 = 8'h10; pwm2 = 8'hC0; pwm3 = 8'hFF;
    step();
    reset_n = 1'b1;
    run(256);
    win(256, c0, c3);
    check_eq("pwm0_duty64", c0, 64);
    check_eq("pwm3_duty255", c3, 255);
    cnt0 = 0;
    run(100);
    pwm0 = 8'h80;
    run(156);
    check_eq("pwm0_cur_period", cnt0, 64);
    win(256, c0, c3);
    check_eq("pwm0_next_period", c0, 128);

    // Group dimming
    reset_n = 1'b0;
    ledout = 8'hFF; mode = 8'h00; grppwm = 8'h80;
    pwm0 = 8'hFF; pwm1 = 8'hFF; pwm2 = 8'hFF; pwm3 = 8'hFF;
    step();
    reset_n = 1'b1;
    run(256);
    win(256, c0, c3);
    check_eq("dim_on", c0, 255);
    grppwm = 8'h00;
    run(256);
    win(256, c0, c3);
    check_eq("dim_zero", c0, 0);
    grppwm = 8'h06;
    run(256);
    win(256, c0, c3);
    check_eq("dim_edge_on", c0, 255);
    win(256, c0, c3);
    check_eq("dim_edge_off", c3, 0);

    // Group blinking and deferred GRPFREQ change
    reset_n = 1'b0;
    ledout = 8'hFF; mode = 8'h08; grpfreq = 8'h01; grppwm = 8'h80;
    step();
    reset_n = 1'b1;
    run(256);
    win(512, c0, c3);
    check_eq("blink_on", c0, 255);
    cnt0 = 0;
    run(100);
    grpfreq = 8'h03;
    run(412);
    check_eq("blink_cur_period", cnt0, 255);
    win(1024, c0, c3);
    check_eq("blink_next_period", c0, 510);

    // Invert, sleep and wake
    reset_n = 1'b0;
    ledout = 8'h00; mode = 8'h04;
    step();
    reset_n = 1'b1;
    run(2);
    check_eq("invert_on", int'(leds), 15);
    mode = 8'h14;
    step();
    check_eq("sleep_off", int'(leds), 0);
    run(5);
    mode = 8'h04;
    step();
    check_eq("wake_invert", int'(leds), 15);
    mode = 8'h14; ledout = 8'hAA; pwm0 = 8'h80;
    run(3);
    mode = 8'h00;
    win(256, c0, c3);
    check_eq("wake_fresh_period", c0, 128);

    // Reset in the middle of a period
    mode = 8'h00; ledout = 8'hAA;
    pwm0 = 8'h80; pwm1 = 8'h80; pwm2 = 8'h80; pwm3 = 8'h80;
    run(300);
    reset_n = 1'b0;
    step();
    check_eq("midrst0", int'(leds), 0);
    step();
    check_eq("midrst1", int'(leds), 0);
    reset_n = 1'b1;
    win(256, c0, c3);
    check_eq("post_rst_first_led0", c0, 0);
    check_eq("post_rst_first_led3", c3, 0);
    win(256, c0, c3);
    check_eq("post_rst_second", c0, 128);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
